// File: rtl/sysarr_tile_sequencer.sv
`default_nettype none
// ============================================================================
// sysarr_tile_sequencer: streams weight / input / partial-sum rows into a
// systolic array and buffers its output rows. SYSARR_SEQ_PERF_EN adds perf ports.
// Revision: 1.0
// ============================================================================
module sysarr_tile_sequencer #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_keep_weights,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [DW*N-1:0]         rd_data,
  output logic                    weight_en,
  output logic                    input_en,
  output logic                    partial_en,
  output logic [$clog2(N)-1:0]    row_in_en,
  output logic [$clog2(N)-1:0]    row_ps_en,
  output logic [DW*N-1:0]         array_in,
  output logic [DW*N-1:0]         array_in_partials,
  input  logic                    fifo_has_space,
  input  logic                    out_en,
  input  logic [$clog2(N)-1:0]    row_out,
  input  logic [DW*N-1:0]         array_output,
  input  logic                    drained,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DW*N-1:0]         res_data,
  output logic [$clog2(N)-1:0]    res_row,
  output logic                    busy,
  output logic                    done
`ifdef SYSARR_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_stall,
  output logic                    perf_err
`endif
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    LOAD_IP  = 3'd2,
    WAIT_OUT = 3'd3,
    FLUSH    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rc_q, rc_d;
  logic            phase_q, phase_d;
  logic [CW-1:0]   oc_q, oc_d;
  logic            wts_valid_q, wts_valid_d;
  logic [RW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [RW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;
  logic [DW*N-1:0] data_mem_q [N];
  logic [DW*N-1:0] data_mem_d [N];
  logic [RW-1:0]   row_mem_q  [N];
  logic [RW-1:0]   row_mem_d  [N];

  logic          capture;
  logic          buf_full;
  logic          push;
  logic          pop;
  logic          slot_ok;
  logic [CW:0]   slots_avail;
  logic [CW:0]   rows_issued;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign buf_full  = (count_q == CW'(N));
  assign res_valid = (count_q != '0);
  assign res_data  = data_mem_q[rd_ptr_q];
  assign res_row   = row_mem_q[rd_ptr_q];
  assign pop       = res_valid && res_ready;
  assign push      = capture && out_en && !buf_full;

  // A new row may enter only if every row still in flight plus this one has a buffer slot.
  assign slots_avail = (CW+1)'(N) - {1'b0, count_q} + {1'b0, oc_q};
  assign rows_issued = {1'b0, CW'(rc_q)};
  assign slot_ok     = (slots_avail > rows_issued);

  always_comb begin
    state_d           = state_q;
    rc_d              = rc_q;
    phase_d           = phase_q;
    oc_d              = oc_q;
    wts_valid_d       = wts_valid_q;
    rd_ready          = 1'b0;
    weight_en         = 1'b0;
    input_en          = 1'b0;
    partial_en        = 1'b0;
    row_in_en         = '0;
    row_ps_en         = '0;
    array_in          = '0;
    array_in_partials = '0;
    capture           = 1'b0;
    done              = 1'b0;

    case (state_q)
      IDLE: begin
        rc_d    = '0;
        phase_d = 1'b0;
        oc_d    = '0;
        if (cmd_valid) begin
          state_d = (cmd_keep_weights && wts_valid_q) ? LOAD_IP : LOAD_W;
        end
      end
      LOAD_W: begin
        rd_ready = 1'b1;
        if (rd_valid) begin
          weight_en = 1'b1;
          array_in  = rd_data;
          if (rc_q == RW'(N-1)) begin
            rc_d        = '0;
            wts_valid_d = 1'b1;
            state_d     = LOAD_IP;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
      end
      LOAD_IP: begin
        capture  = 1'b1;
        rd_ready = fifo_has_space && slot_ok;
        if (rd_valid && fifo_has_space && slot_ok) begin
          if (!phase_q) begin
            input_en  = 1'b1;
            row_in_en = rc_q;
            array_in  = rd_data;
            phase_d   = 1'b1;
          end else begin
            partial_en        = 1'b1;
            row_ps_en         = rc_q;
            array_in_partials = rd_data;
            phase_d           = 1'b0;
            if (rc_q == RW'(N-1)) begin
              rc_d    = '0;
              state_d = WAIT_OUT;
            end else begin
              rc_d = rc_q + 1'b1;
            end
          end
        end
      end
      WAIT_OUT: begin
        capture = 1'b1;
        if (oc_q == CW'(N)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if ((count_q == '0) && drained) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The array cannot be stalled: every captured out_en counts, even if dropped.
    if (capture && out_en) begin
      oc_d = oc_q + 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    err_d      = err_q | (capture && out_en && buf_full);
    data_mem_d = data_mem_q;
    row_mem_d  = row_mem_q;
    if (push) begin
      data_mem_d[wr_ptr_q] = array_output;
      row_mem_d[wr_ptr_q]  = row_out;
      wr_ptr_d = (wr_ptr_q == RW'(N-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == RW'(N-1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      rc_q        <= '0;
      phase_q     <= 1'b0;
      oc_q        <= '0;
      wts_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        data_mem_q[i] <= '0;
        row_mem_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      phase_q     <= phase_d;
      oc_q        <= oc_d;
      wts_valid_q <= wts_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      data_mem_q  <= data_mem_d;
      row_mem_q   <= row_mem_d;
    end
  end

`ifdef SYSARR_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q,  perf_stall_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (busy && (perf_cycles_q != '1)) begin
      perf_cycles_d = perf_cycles_q + 32'd1;
    end
    if (((state_q == LOAD_W) || (state_q == LOAD_IP)) && rd_valid && !rd_ready &&
        (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
  assign perf_err    = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
`default_nettype wire
